// File: rtl/pmu_pkg.sv
// Shared PMU key-path definitions: controller states and key geometry.
// Key width defaults and word-count helpers live here.
package pmu_pkg;

  localparam int KEY_LENGTH_DEF = 128;
  localparam int WORD_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    COMMIT = 3'd2,
    READY  = 3'd3,
    ZERO   = 3'd4
  } state_t;

  function automatic int nwords(
    input int key_len,
    input int word_w
  );
    return key_len / word_w;
  endfunction

  function automatic int cnt_width(
    input int n
  );
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_word_shifter.sv
// Key assembly: MSB-first word shift register and accepted-word counter.
// done flags that the word being shifted in this cycle completes the key.
module key_word_shifter
  import pmu_pkg::*;
#(
  parameter int KEY_LENGTH = KEY_LENGTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic [WORD_WIDTH-1:0] word_data,
  output logic [KEY_LENGTH-1:0] shift_q,
  output logic                  done
);

  localparam int NWORDS = nwords(KEY_LENGTH, WORD_WIDTH);
  localparam int CW     = cnt_width(NWORDS);
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  logic [CW-1:0]         cnt_q;
  logic [KEY_LENGTH-1:0] shift_d;

  // Next shift value: older words move toward the MSB end.
  generate
    if (KEY_LENGTH > WORD_WIDTH) begin : g_multi
      assign shift_d = {
        shift_q[KEY_LENGTH-WORD_WIDTH-1:0],
        word_data
      };
    end else begin : g_single
      assign shift_d = word_data;
    end
  endgenerate

  assign done = shift_en && (cnt_q == LAST);

  // Shift register and counter; clear wins over shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (shift_en) begin
      shift_q <= shift_d;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/key_load_ctrl.sv
// PMU key load sequencer: assemble, commit, grant and zeroize the key.
// Optional write-once locking is built when KEY_LOCK_EN is defined.
module key_load_ctrl
  import pmu_pkg::*;
#(
  parameter int KEY_LENGTH = KEY_LENGTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_ready,
  input  logic                  zeroize,
  output logic                  key_write,
  output logic [KEY_LENGTH-1:0] key_data,
  output logic                  key_valid,
  input  logic                  key_req,
  output logic                  key_ack,
  output logic                  busy,
  output logic                  locked
);

  state_t state_q, state_d;

  logic                  clr;
  logic                  shift_en;
  logic                  done;
  logic [KEY_LENGTH-1:0] shift_q;
  logic                  reload;
  logic                  ack_fire;
  logic                  ack_q;
  logic                  served_q;

  key_word_shifter #(
    .KEY_LENGTH (KEY_LENGTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .shift_en  (shift_en),
    .word_data (word_data),
    .shift_q   (shift_q),
    .done      (done)
  );

`ifdef KEY_LOCK_EN
  logic lock_q;

  // Lock sets on commit; only zeroize or reset release it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (zeroize || state_q == ZERO) begin
      lock_q <= 1'b0;
    end else if (state_q == COMMIT) begin
      lock_q <= 1'b1;
    end
  end

  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  assign reload = load_start && !locked;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and shifter control; zeroize overrides everything.
  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    shift_en = 1'b0;
    if (zeroize) begin
      state_d = ZERO;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_start) begin
            state_d = LOAD;
            clr     = 1'b1;
          end
        end
        LOAD: begin
          shift_en = word_valid;
          if (done) begin
            state_d = COMMIT;
          end
        end
        COMMIT: begin
          state_d = READY;
        end
        READY: begin
          if (reload) begin
            state_d = LOAD;
            clr     = 1'b1;
          end
        end
        ZERO: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    if (state_q == ZERO) begin
      clr = 1'b1;
    end
  end

  // One grant per rising request edge while the key is held.
  assign ack_fire = (state_q == READY) && key_req
                 && !served_q && !zeroize && !reload;

  // Grant pulse and request-served tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q    <= 1'b0;
      served_q <= 1'b0;
    end else begin
      ack_q <= ack_fire;
      if (!key_req || state_q != READY) begin
        served_q <= 1'b0;
      end else if (ack_fire) begin
        served_q <= 1'b1;
      end
    end
  end

  assign key_ack    = ack_q;
  assign word_ready = (state_q == LOAD);
  assign key_valid  = (state_q == READY);
  assign key_write  = (state_q == COMMIT) || (state_q == ZERO);
  assign key_data   = (state_q == COMMIT) ? shift_q : '0;
  assign busy       = (state_q == LOAD) || (state_q == COMMIT)
                   || (state_q == ZERO);

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl with hand-computed expectations.
// Covers both default and KEY_LOCK_EN builds.
module tb_key_load_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_start;
  logic         word_valid;
  logic [31:0]  word_data;
  logic         word_ready;
  logic         zeroize;
  logic         key_write;
  logic [127:0] key_data;
  logic         key_valid;
  logic         key_req;
  logic         key_ack;
  logic         busy;
  logic         locked;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int ack_cnt = 0;

  localparam logic [127:0] K1 =
    128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] K2 =
    128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
  localparam logic [127:0] KP =
    128'h11111111_22222222_33333333_44444444;

`ifdef KEY_LOCK_EN
  localparam int EXP_WR  = 6;
  localparam logic EXP_LK = 1'b1;
`else
  localparam int EXP_WR  = 4;
  localparam logic EXP_LK = 1'b0;
`endif

  key_load_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .zeroize    (zeroize),
    .key_write  (key_write),
    .key_data   (key_data),
    .key_valid  (key_valid),
    .key_req    (key_req),
    .key_ack    (key_ack),
    .busy       (busy),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // Count write strobes and grant pulses seen at clock edges.
  always @(posedge clk) begin
    if (key_write) wr_cnt <= wr_cnt + 1;
    if (key_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(
    input logic [127:0] k,
    input int           gap
  );
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        word_valid = 1'b0;
        chk("gap_ready", word_ready, 1);
        tick();
      end
      word_valid = 1'b1;
      word_data  = k[127-32*i -: 32];
      chk("load_ready", word_ready, 1);
      tick();
    end
    word_valid = 1'b0;
  endtask

  task automatic expect_commit(
    input logic [127:0] k
  );
    chk("cm_write", key_write, 1);
    chk("cm_data", key_data, k);
    chk("cm_valid", key_valid, 0);
    tick();
    chk("rd_write", key_write, 0);
    chk("rd_data", key_data, 0);
    chk("rd_valid", key_valid, 1);
    chk("rd_busy", busy, 0);
    chk("rd_locked", locked, EXP_LK);
  endtask

  task automatic enter_load();
`ifdef KEY_LOCK_EN
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    tick();
`endif
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("enter_ready", word_ready, 1);
  endtask

  initial begin
    int wr0;
    rst        = 1'b1;
    load_start = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    zeroize    = 1'b0;
    key_req    = 1'b0;
    #3;
    chk("rst_ready", word_ready, 0);
    chk("rst_write", key_write, 0);
    chk("rst_data", key_data, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_ack", key_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back load.
    load_start = 1'b1;
    chk("idle_ready", word_ready, 0);
    tick();
    load_start = 1'b0;
    chk("ld_ready", word_ready, 1);
    chk("ld_busy", busy, 1);
    load_key(K1, 0);
    expect_commit(K1);

    // Grant handshake.
    key_req = 1'b1;
    tick();
    chk("ack1_on", key_ack, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ack1_off", key_ack, 0);
    end
    key_req = 1'b0;
    tick();
    chk("ack_low", key_ack, 0);
    key_req = 1'b1;
    tick();
    chk("ack2_on", key_ack, 1);
    key_req = 1'b0;
    tick();
    chk("ack2_off", key_ack, 0);
    chk("ack_cnt2", ack_cnt, 2);

    // Reload attempt from READY.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
`ifdef KEY_LOCK_EN
    chk("lk_ready", word_ready, 0);
    chk("lk_valid", key_valid, 1);
    chk("lk_locked", locked, 1);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk("lk_zwrite", key_write, 1);
    chk("lk_zdata", key_data, 0);
    chk("lk_unlock", locked, 0);
    tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
`endif
    chk("rl_ready", word_ready, 1);
    chk("rl_valid", key_valid, 0);

    // Gapped load.
    load_key(K1, 3);
    expect_commit(K1);

    // Zeroize after two words.
    enter_load();
    word_valid = 1'b1;
    word_data  = KP[127:96];
    tick();
    word_data  = KP[95:64];
    tick();
    word_data  = KP[63:32];
    zeroize    = 1'b1;
    wr0        = wr_cnt;
    tick();
    zeroize    = 1'b0;
    word_valid = 1'b0;
    chk("z_write", key_write, 1);
    chk("z_data", key_data, 0);
    chk("z_busy", busy, 1);
    tick();
    chk("z_idle_wr", key_write, 0);
    chk("z_idle_vld", key_valid, 0);
    chk("z_idle_busy", busy, 0);
    chk("z_idle_rdy", word_ready, 0);
    tick();
    chk("z_no_commit", key_write, 0);
    chk("z_wr_delta", wr_cnt - wr0, 1);

    // Reset mid-load.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    word_valid = 1'b1;
    word_data  = KP[127:96];
    tick();
    word_data  = KP[95:64];
    tick();
    word_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mr_ready", word_ready, 0);
    chk("mr_busy", busy, 0);
    chk("mr_write", key_write, 0);
    chk("mr_data", key_data, 0);
    chk("mr_valid", key_valid, 0);
    tick();
    rst = 1'b0;
    tick();

    // Fresh load with early request.
    key_req    = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("er_ack_ld", key_ack, 0);
    load_key(K2, 0);
    chk("er_ack_cm", key_ack, 0);
    expect_commit(K2);
    chk("er_ack_rd", key_ack, 0);
    tick();
    chk("er_ack_on", key_ack, 1);
    key_req = 1'b0;
    tick();
    chk("er_ack_off", key_ack, 0);
    chk("ack_total", ack_cnt, 3);
    chk("wr_total", wr_cnt, EXP_WR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
